spd_divider: RTL
================

// Module: spd_divider
// PURPOSE
//  Signed sequential shift-subtract divider: inverse of the serial-parallel multiplier.
//  Takes a 2W-bit signed dividend (product width) and W-bit signed divisor; returns W-bit
//  quotient/remainder after start/done handshake. Sits beside SPM in the arithmetic datapath.
// PARAMETERS
//  W  8  operand width; dividend 2W bits, divisor/quotient/remainder W bits
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous, active-low reset
//  start      in   1    begin operation; sampled only in IDLE
//  dividend   in   2W   signed dividend, captured on accepted start
//  divisor    in   W    signed divisor, captured on accepted start
//  quot       out  W    signed quotient, truncated toward zero
//  rem        out  W    signed remainder; sign follows dividend
//  done       out  1    one-cycle pulse; result valid from this cycle on
//  busy       out  1    high from edge after accepted start until done pulse ends
//  sign_flag  out  1    dividend[2W-1] ^ divisor[W-1], registered with result
//  ovf        out  1    true quotient not representable in W signed bits
//  dbz        out  1    divisor was zero
// BEHAVIOUR
//  - rst low (any time, incl. mid-operation): state IDLE, counter 0, all outputs 0; no done.
//  - FSM: IDLE -> CALC -> FIX -> IDLE; divide-by-zero path IDLE -> FIX.
//  - Edge E0 (IDLE, start=1): latch |dividend| (2W unsigned), |divisor| (W unsigned), signs;
//    busy=1; counter=0. divisor==0 -> FIX directly.
//  - Edges E1..E2W (CALC): one restoring step per edge, MSB first: shift partial remainder left,
//    shift in next dividend bit; if partial >= |divisor| subtract, quotient bit=1. 2W steps total.
//  - Edge E2W+1 (FIX): negate quotient magnitude if sign_flag; negate remainder if dividend
//    negative; write quot/rem/sign_flag/ovf/dbz; done=1. Next edge: done=0, busy=0, IDLE.
//  - Latency: done high after edge E2W+1 (17 edges for W=8); divide-by-zero: after E1.
//  - Divide-by-zero: quot=0, rem=0, ovf=0, dbz=1, sign_flag computed normally.
//  - Overflow: ovf=1 when |q| > 2^(W-1)-1 (positive result) or > 2^(W-1) (negative).
//  - |rem| < |divisor| <= 2^(W-1), so rem always fits; never flagged.
//  - Dividend -2^(2W-1): magnitude 2^(2W-1) fits 2W unsigned bits; handled normally.
//  - start while busy: ignored, no effect on operation in flight.
//  - start in same cycle as done pulse: ignored (FSM not yet IDLE).
//  - quot/rem/flags hold last result until next done; cleared only by reset.
// CONFIGURATION
//  DIV_SAT_EN defined: on ovf, quot saturates to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
//  DIV_SAT_EN undefined: on ovf, quot = low W bits of two's-complement true quotient.
//  ovf flag behaves identically in both builds.
// TESTING (W=8)
//  1. 120 / 10 -> quot=12, rem=0, ovf=0, dbz=0, done exactly 17 edges after start edge.
//  2. -61 / 3 -> quot=-20, rem=-1, sign_flag=1; 100 / -7 -> quot=-14, rem=2, sign_flag=1.
//  3. 25 / 0 -> done after 1 edge, dbz=1, quot=0, rem=0, ovf=0.
//  4. -128 / -1 -> ovf=1; quot=127 with DIV_SAT_EN, quot=-128 without.
//     1000 / 2 -> ovf=1; quot=127 with DIV_SAT_EN, quot=-12 (0xF4) without.
//  5. Re-pulse start at edge E5 with new operands -> ignored; first result unchanged,
//     done pulses once.
//  6. Drive rst low at edge E5 -> outputs 0, busy=0, no done;
//     after release, fresh 64 / -8 -> quot=-8, rem=0.

Source files
------------

// File: rtl/spd_divider.sv
// spd_divider: signed sequential restoring divider.
//
// Divides a 2W-bit signed dividend by a W-bit signed divisor. The quotient is
// truncated toward zero, and the remainder takes the sign of the dividend.
// Operands are converted to magnitudes when start is accepted. One restoring
// step is then performed per clock, MSB first, for 2W clocks. A final FIX cycle
// restores the signs, flags overflow and pulses done.
//
// Build option: define DIV_SAT_EN to saturate quot on overflow. With
// DIV_SAT_EN undefined, quot is the low W bits of the true quotient
// (wrap-around). The ovf flag behaves the same in both builds.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// CALC  | 2W restoring shift-subtract steps, one per clock
// FIX   | first cycle: sign-correct and write results, done=1;
//       | second cycle: drop done/busy and return to IDLE
module spd_divider #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic [W-1:0]     quot,
    output logic [W-1:0]     rem,
    output logic             done,
    output logic             busy,
    output logic             sign_flag,
    output logic             ovf,
    output logic             dbz
);

    localparam int CW = $clog2(2 * W);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * W - 1);

    // Largest quotient magnitudes that still fit in W signed bits.
    localparam logic [2*W-1:0] LIM_NEG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [2*W-1:0] LIM_POS = LIM_NEG - 1'b1;
    localparam logic [W-1:0]   SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   SAT_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state;
    logic [2*W-1:0] shreg;      // dividend bits shift out, quotient bits shift in
    logic [W-1:0]   part;       // partial remainder magnitude
    logic [W-1:0]   dvs_mag;
    logic           neg_dvd;
    logic           neg_q;
    logic           zero_div;
    logic [CW-1:0]  cnt;

    logic [2*W-1:0] dvd_abs;
    logic [W-1:0]   dvs_abs;
    logic [W:0]     shifted;
    logic           take_sub;
    logic [W-1:0]   next_part;
    logic [W-1:0]   q_wrap;
    logic           ovf_c;
    logic [W-1:0]   quot_c;
    logic [W-1:0]   rem_c;

    // Operand magnitudes, the restoring step and the sign/overflow fix-up.
    always_comb begin
        dvd_abs   = dividend[2*W-1] ? -dividend : dividend;
        dvs_abs   = divisor[W-1]    ? -divisor  : divisor;

        // The partial remainder is always below |divisor| <= 2^(W-1), so
        // after the shift it fits in W+1 bits. The difference fits in W bits.
        shifted   = {part, shreg[2*W-1]};
        take_sub  = (shifted >= {1'b0, dvs_mag});
        next_part = take_sub ? (shifted[W-1:0] - dvs_mag) : shifted[W-1:0];

        // The low W bits of a negation depend only on the low W bits of the
        // operand.
        q_wrap    = neg_q ? -shreg[W-1:0] : shreg[W-1:0];
        ovf_c     = neg_q ? (shreg > LIM_NEG) : (shreg > LIM_POS);
`ifdef DIV_SAT_EN
        quot_c    = ovf_c ? (neg_q ? SAT_NEG : SAT_POS) : q_wrap;
`else
        quot_c    = q_wrap;
`endif
        rem_c     = neg_dvd ? -part : part;
    end

    // Control FSM with registered datapath and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            part      <= '0;
            dvs_mag   <= '0;
            neg_dvd   <= 1'b0;
            neg_q     <= 1'b0;
            zero_div  <= 1'b0;
            cnt       <= '0;
            quot      <= '0;
            rem       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            sign_flag <= 1'b0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        part     <= '0;
                        neg_dvd  <= dividend[2*W-1];
                        neg_q    <= dividend[2*W-1] ^ divisor[W-1];
                        zero_div <= (divisor == '0);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    shreg <= {shreg[2*W-2:0], take_sub};
                    part  <= next_part;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!done) begin
                        done      <= 1'b1;
                        sign_flag <= neg_q;
                        dbz       <= zero_div;
                        if (zero_div) begin
                            quot <= '0;
                            rem  <= '0;
                            ovf  <= 1'b0;
                        end else begin
                            quot <= quot_c;
                            rem  <= rem_c;
                            ovf  <= ovf_c;
                        end
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
